// File: rtl/cpu_sram_bridge_if.sv
// rtl/cpu_sram_bridge_if.sv - core SRAM ports and memory bus bundle for cpu_sram_bridge
`timescale 1ns/1ps
interface cpu_sram_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // instruction port (core side)
    logic              inst_sram_en;
    logic [BE_W-1:0]   inst_sram_wen;
    logic [ADDR_W-1:0] inst_sram_addr;
    logic [DATA_W-1:0] inst_sram_wdata;
    logic [DATA_W-1:0] inst_sram_rdata;

    // data port (core side)
    logic              data_sram_en;
    logic [BE_W-1:0]   data_sram_wen;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic [DATA_W-1:0] data_sram_rdata;

    // pipeline control
    logic              stallreq;

    // memory bus
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [BE_W-1:0]   mem_req_wen;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    // the bridge itself
    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata,
        output stallreq,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_rdata
    );

    // the core and the memory facing the bridge
    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata,
        input  stallreq,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/cpu_sram_bridge.sv
// rtl/cpu_sram_bridge.sv - serialises instruction and data SRAM ports onto one memory bus
`timescale 1ns/1ps
module cpu_sram_bridge #(
    parameter bit DATA_FIRST = 1'b1,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic             clk,
    input  logic             resetn,
    cpu_sram_bridge_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    logic              sel_data;      // 1: the access in flight belongs to the data port
    logic              inst_done;
    logic              data_done;
    logic              req_valid;
    logic [BE_W-1:0]   req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] inst_rdata;
    logic [DATA_W-1:0] data_rdata;

    logic pending_i;
    logic pending_d;
    logic stall;
    logic pick_data;

    // An access is pending while its port is enabled and its result has not
    // yet been delivered in the current pipeline step.
    assign pending_i = bus.inst_sram_en & ~inst_done;
    assign pending_d = bus.data_sram_en & ~data_done;
    assign stall     = pending_i | pending_d;

    // Data wins a tie only when DATA_FIRST is set; a lone request always wins.
    assign pick_data = pending_d & (DATA_FIRST | ~pending_i);

    assign bus.stallreq        = stall;
    assign bus.mem_req_valid   = req_valid;
    assign bus.mem_req_wen     = req_wen;
    assign bus.mem_req_addr    = req_addr;
    assign bus.mem_req_wdata   = req_wdata;
    assign bus.inst_sram_rdata = inst_rdata;
    assign bus.data_sram_rdata = data_rdata;

    // Arbitration/handshake FSM with done flags and read-data holding registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            sel_data   <= 1'b0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
            req_valid  <= 1'b0;
            req_wen    <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            // The pipeline advances on any edge without a stall, so the
            // per-step completion record is discarded there.
            if (!stall) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (stall) begin
                        sel_data  <= pick_data;
                        req_valid <= 1'b1;
                        state     <= REQ;
                        if (pick_data) begin
                            req_wen   <= bus.data_sram_wen;
                            req_addr  <= bus.data_sram_addr;
                            req_wdata <= bus.data_sram_wdata;
                        end else begin
                            req_wen   <= bus.inst_sram_wen;
                            req_addr  <= bus.inst_sram_addr;
                            req_wdata <= bus.inst_sram_wdata;
                        end
                    end
                end

                REQ: begin
                    // Payload is held; a response seen here is a protocol
                    // violation and is deliberately not looked at.
                    if (bus.mem_req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        // Stores also land here; the value is meaningless to
                        // the core but keeps the datapath uniform.
                        if (sel_data) begin
                            data_rdata <= bus.mem_resp_rdata;
                            data_done  <= 1'b1;
                        end else begin
                            inst_rdata <= bus.mem_resp_rdata;
                            inst_done  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end

                default: begin
                    req_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
